// File: rtl/share_split.sv
// Bit-serial additive secret sharing: g = r, e = (x - r) mod 2^N.
// One full-subtractor step per clock, LSB first.
module share_split #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] r_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] g_share,
    output logic [N-1:0] e_share,
    output logic         borrow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   x_q;
    logic [N-1:0]   r_q;
    logic [N-1:0]   gh_q;
    logic [N-1:0]   e_q;
    logic           b_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   g_out_q;
    logic [N-1:0]   e_out_q;
    logic           bo_q;

    logic           x0;
    logic           r0;
    logic           d;
    logic           b_d;
    logic [N-1:0]   e_d;

    always_comb begin
        x0  = x_q[0];
        r0  = r_q[0];
        d   = x0 ^ r0 ^ b_q;
        b_d = (~x0 & r0) | (~(x0 ^ r0) & b_q);
        e_d = {d, e_q[N-1:1]};
    end

    // Output registers only load on the final SUB step, so they hold across IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            r_q     <= '0;
            gh_q    <= '0;
            e_q     <= '0;
            b_q     <= 1'b0;
            cnt_q   <= '0;
            g_out_q <= '0;
            e_out_q <= '0;
            bo_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= x_in;
                        r_q     <= r_in;
                        gh_q    <= r_in;
                        b_q     <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    x_q   <= x_q >> 1;
                    r_q   <= r_q >> 1;
                    e_q   <= e_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        g_out_q <= gh_q;
                        e_out_q <= e_d;
                        bo_q    <= b_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE) & ~rst;
    assign g_share   = g_out_q;
    assign e_share   = e_out_q;
    assign borrow    = bo_q;

endmodule

// File: tb/tb_share_split.sv
// Bench for share_split: N=8 vector table, corner sequences,
// and a parallel N=8 / N=16 random soak against a queue scoreboard.
module tb_share_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, b8;
    logic [7:0]  x8, r8, g8, e8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, b16;
    logic [15:0] x16, r16, g16, e16;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] g;
        logic [15:0] e;
        logic        b;
        int          acc;
    } exp_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] e;
        logic       b;
    } vec_t;

    exp_t q8[$];
    exp_t q16[$];

    share_split #(.N(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .x_in(x8), .r_in(r8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .g_share(g8), .e_share(e8), .borrow(b8)
    );

    share_split #(.N(16)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .x_in(x16), .r_in(r16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .g_share(g16), .e_share(e16), .borrow(b16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    // Output monitors: latency, payload, recombination, stall stability.
    logic        hold8 = 0, ov8p = 0;
    logic [16:0] snap8;
    always @(negedge clk) begin
        exp_t ex;
        logic [7:0] s;
        if (rst) begin
            hold8 = 0;
            ov8p  = 0;
        end else begin
            if (hold8) begin
                chk("stall8_valid", out_valid8, 1);
                chk("stall8_data", {g8, e8, b8}, snap8);
            end
            if (out_valid8) chk("busy8_in_ready", in_ready8, 0);
            if (out_valid8 && !ov8p) begin
                if (q8.size() == 0) chk("spurious8", 1, 0);
                else chk("lat8", cyc - q8[0].acc, 8);
            end
            if (out_valid8 && out_ready8 && q8.size() > 0) begin
                ex = q8.pop_front();
                s  = g8 + e8;
                chk("g8", g8, ex.g[7:0]);
                chk("e8", e8, ex.e[7:0]);
                chk("b8", b8, ex.b);
                chk("sum8", s, ex.x[7:0]);
            end
            hold8 = out_valid8 && !out_ready8;
            snap8 = {g8, e8, b8};
            ov8p  = out_valid8;
        end
    end

    logic        hold16 = 0, ov16p = 0;
    logic [32:0] snap16;
    always @(negedge clk) begin
        exp_t ex;
        logic [15:0] s;
        if (rst) begin
            hold16 = 0;
            ov16p  = 0;
        end else begin
            if (hold16) begin
                chk("stall16_valid", out_valid16, 1);
                chk("stall16_data", {g16, e16, b16}, snap16);
            end
            if (out_valid16) chk("busy16_in_ready", in_ready16, 0);
            if (out_valid16 && !ov16p) begin
                if (q16.size() == 0) chk("spurious16", 1, 0);
                else chk("lat16", cyc - q16[0].acc, 16);
            end
            if (out_valid16 && out_ready16 && q16.size() > 0) begin
                ex = q16.pop_front();
                s  = g16 + e16;
                chk("g16", g16, ex.g);
                chk("e16", e16, ex.e);
                chk("b16", b16, ex.b);
                chk("sum16", s, ex.x);
            end
            hold16 = out_valid16 && !out_ready16;
            snap16 = {g16, e16, b16};
            ov16p  = out_valid16;
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic pair8(input logic [7:0] x, r, eg, ee, input logic eb,
                         input int gap, input int hold, input bit churn);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid8 = 1; x8 = x; r8 = r;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready8) begin
            chk("accept8_timeout", 1, 0);
            in_valid8 = 0;
            return;
        end
        @(posedge clk); #1;
        q8.push_back('{x: 16'(x), g: 16'(eg), e: 16'(ee), b: eb, acc: cyc});
        in_valid8 = 0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            if (churn) begin
                x8 = 8'($urandom); r8 = 8'($urandom);
                in_valid8 = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1; n++;
        end
        if (!out_valid8) chk("done8_timeout", 1, 0);
        repeat (hold) begin
            if (churn) begin
                x8 = 8'($urandom); r8 = 8'($urandom);
                in_valid8 = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        out_ready8 = 1;
        @(posedge clk); #1;
        out_ready8 = 0; in_valid8 = 0;
        chk("idle8_in_ready", in_ready8, 1);
    endtask

    task automatic pair16(input logic [15:0] x, r, input int gap,
                          input int hold);
        int n;
        logic [15:0] d;
        d = x - r;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid16 = 1; x16 = x; r16 = r;
        n = 0;
        @(negedge clk);
        while (!in_ready16 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready16) begin
            chk("accept16_timeout", 1, 0);
            in_valid16 = 0;
            return;
        end
        @(posedge clk); #1;
        q16.push_back('{x: x, g: r, e: d, b: (x < r), acc: cyc});
        in_valid16 = 0;
        n = 0;
        while (!out_valid16 && n < 60) begin
            x16 = 16'($urandom); r16 = 16'($urandom);
            in_valid16 = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        if (!out_valid16) chk("done16_timeout", 1, 0);
        repeat (hold) begin
            in_valid16 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready16 = 1;
        @(posedge clk); #1;
        out_ready16 = 0; in_valid16 = 0;
        chk("idle16_in_ready", in_ready16, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        bit   seen;
        vt[0] = '{8'h05, 8'h03, 8'h03, 8'h02, 1'b0};
        vt[1] = '{8'h03, 8'h05, 8'h05, 8'hFE, 1'b1};
        vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[3] = '{8'h00, 8'h01, 8'h01, 8'hFF, 1'b1};
        vt[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vt[5] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0};
        vt[6] = '{8'h00, 8'hFF, 8'hFF, 8'h01, 1'b1};
        vt[7] = '{8'h80, 8'h01, 8'h01, 8'h7F, 1'b0};
        vt[8] = '{8'h7F, 8'h80, 8'h80, 8'hFF, 1'b1};

        rst = 1;
        in_valid8 = 0; x8 = 0; r8 = 0; out_ready8 = 0;
        in_valid16 = 0; x16 = 0; r16 = 0; out_ready16 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready8", in_ready8, 0);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_out8", {g8, e8, b8}, 0);
        chk("rst_in_ready16", in_ready16, 0);
        chk("rst_out16", {g16, e16, b16}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready8", in_ready8, 1);
        chk("post_rst_in_ready16", in_ready16, 1);
        chk("post_rst_out_valid8", out_valid8, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            pair8(vt[i].x, vt[i].r, vt[i].g, vt[i].e, vt[i].b, 0, 0, 0);

        // Backpressure with churning inputs during SUB and DONE.
        pair8(8'hA5, 8'h5A, 8'h5A, 8'h4B, 1'b0, 1, 5, 1);

        // Reset in the third SUB cycle, overlapping an in_valid pulse.
        in_valid8 = 1; x8 = 8'h80; r8 = 8'h01;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid8 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; in_valid8 = 1; x8 = 8'h33; r8 = 8'h11;
        @(negedge clk);
        chk("midrst_in_ready8", in_ready8, 0);
        chk("midrst_out_valid8", out_valid8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0; in_valid8 = 0;
        @(negedge clk);
        chk("midrst_out8_zero", {g8, e8, b8}, 0);
        chk("midrst_idle8", in_ready8, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid8) seen = 1;
        end
        chk("abort8_no_output", seen, 0);
        @(posedge clk); #1;
        pair8(8'h10, 8'h20, 8'h20, 8'hF0, 1'b1, 0, 0, 0);

        fork
            for (int i = 0; i < 1000; i++) begin
                logic [7:0] x, r, d;
                x = 8'($urandom); r = 8'($urandom); d = x - r;
                pair8(x, r, r, d, (x < r), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1);
            end
            for (int j = 0; j < 1000; j++) begin
                pair16(16'($urandom), 16'($urandom), $urandom_range(0, 2),
                       $urandom_range(0, 3));
            end
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
